// File: rtl/quad_pkg.sv
// Shared phase-state constants and transition decoding for the quadrature decoder.
package quad_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } step_e;

    // Position of a phase state along the forward cycle 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        logic [1:0] p;
        p = 2'd0;
        case (s)
            S00: p = 2'd0;
            S01: p = 2'd1;
            S11: p = 2'd2;
            S10: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Forward distance mod 4: 1 is a step up, 3 a step down, 2 a double-bit jump.
    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        step_e      r;
        d = 2'(gray_pos(cur) - gray_pos(prev));
        case (d)
            2'd0: r = NONE;
            2'd1: r = UP;
            2'd3: r = DOWN;
            default: r = ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for an asynchronous input, clears to 0.
module sync_ff #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes qa/qb, decodes Gray transitions into
// step/dir/err pulses and tracks position in a loadable up/down counter.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qa,
    input  logic             qb,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             step,
    output logic             dir,
    output logic             err
);

    logic       a_s;
    logic       b_s;
    logic [1:0] cur;
    logic [1:0] prev;
    step_e      code_c;

    sync_ff #(.N(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (qa),
        .q   (a_s)
    );

    sync_ff #(.N(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (qb),
        .q   (b_s)
    );

    assign cur = {a_s, b_s};

    // Classify the transition between the previous and current phase state.
    always_comb begin
        code_c = NONE;
        code_c = decode_step(prev, cur);
    end

    // Register phase history, pulses, direction and position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= S00;
            out  <= '0;
            step <= 1'b0;
            dir  <= 1'b0;
            err  <= 1'b0;
        end else begin
            prev <= cur;
            step <= (code_c == UP) || (code_c == DOWN);
            err  <= (code_c == ILLEGAL);
            if (code_c == UP) begin
                dir <= 1'b1;
            end else if (code_c == DOWN) begin
                dir <= 1'b0;
            end
            // Load wins over counting; a coincident step is still reported.
            if (load) begin
                out <= in;
            end else if (code_c == UP) begin
                out <= out + WIDTH'(1);
            end else if (code_c == DOWN) begin
                out <= out - WIDTH'(1);
            end
        end
    end

endmodule
